// File: rtl/ice_panel_pkg.sv
// Shared constants for the ICE front-panel controller: button roles and view-select width.
package ice_panel_pkg;

    localparam int unsigned PB_RESET = 0;
    localparam int unsigned PB_CHSEL = 1;

    // One extra view beyond the debug channels for the heartbeat/button display.
    function automatic int unsigned ch_sel_width(input int unsigned num_ch);
        return $clog2(num_ch + 1);
    endfunction

endpackage

// File: rtl/ice_debounce.sv
// One pushbutton: two-flop synchroniser, stable-count debounce, debounced level and press pulse.
module ice_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 50000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic pb_n,
    output logic level,
    output logic press
);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             pressed_c;

    assign pressed_c = ~sync2;

    // A new level is accepted only after DEBOUNCE_CYC consecutive disagreeing samples.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= pb_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (pressed_c == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                level <= pressed_c;
                press <= pressed_c;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ice_panel_ctrl.sv
// Front-panel controller: debounced buttons, stretched soft reset, and debug-channel/heartbeat LED mux.
module ice_panel_ctrl
    import ice_panel_pkg::*;
#(
    parameter int unsigned NUM_PB       = 4,
    parameter int unsigned DEBOUNCE_CYC = 50000,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned LED_W        = 8,
    parameter int unsigned RST_STRETCH  = 16,
    parameter int unsigned HB_LOG2      = 24
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_PB-1:0]                 pb_n,
    input  logic [NUM_CH*LED_W-1:0]           dbg_in,
    output logic [NUM_PB-1:0]                 pb_level,
    output logic [NUM_PB-1:0]                 pb_press,
    output logic                              soft_reset,
    output logic [ch_sel_width(NUM_CH)-1:0]   ch_sel,
    output logic [LED_W-1:0]                  led
);

    localparam int unsigned CH_W = ch_sel_width(NUM_CH);
    localparam int unsigned ST_W = $clog2(RST_STRETCH + 1);

    logic [ST_W-1:0]    stretch_cnt;
    logic [ST_W-1:0]    stretch_nxt_c;
    logic               stretch_nz;
    logic [HB_LOG2-1:0] hb_cnt;
    logic [LED_W-1:0]   sel_ch_c;
    logic [LED_W-1:0]   hb_view_c;

    for (genvar i = 0; i < NUM_PB; i++) begin : g_pb
        ice_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .CNT_W        (CNT_W)
        ) u_debounce (
            .clk    (clk),
            .resetn (resetn),
            .pb_n   (pb_n[i]),
            .level  (pb_level[i]),
            .press  (pb_press[i])
        );
    end

    always_comb begin
        stretch_nxt_c = stretch_cnt;
        if (pb_level[PB_RESET]) begin
            stretch_nxt_c = ST_W'(RST_STRETCH);
        end else if (stretch_cnt != '0) begin
            stretch_nxt_c = stretch_cnt - ST_W'(1);
        end
    end

    // stretch_nz mirrors (stretch_cnt != 0) so soft_reset is an OR of two flops with no decode glitch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stretch_cnt <= ST_W'(RST_STRETCH);
            stretch_nz  <= 1'(RST_STRETCH != 0);
        end else begin
            stretch_cnt <= stretch_nxt_c;
            stretch_nz  <= (stretch_nxt_c != '0);
        end
    end

    assign soft_reset = pb_level[PB_RESET] | stretch_nz;

    always_comb begin
        sel_ch_c = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch_sel == CH_W'(k)) begin
                sel_ch_c = dbg_in[k*LED_W +: LED_W];
            end
        end
    end

    always_comb begin
        hb_view_c                = '0;
        hb_view_c[LED_W-1]       = hb_cnt[HB_LOG2-1];
        hb_view_c[NUM_PB-1:0]    = pb_level;
    end

    // Soft reset wins over a same-cycle channel-select press and forces the lamp test.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ch_sel <= '0;
            hb_cnt <= '0;
            led    <= '0;
        end else if (soft_reset) begin
            ch_sel <= '0;
            hb_cnt <= '0;
            led    <= '1;
        end else begin
            hb_cnt <= hb_cnt + HB_LOG2'(1);
            if (pb_press[PB_CHSEL]) begin
                ch_sel <= (ch_sel == CH_W'(NUM_CH)) ? '0 : ch_sel + CH_W'(1);
            end
            led <= (ch_sel < CH_W'(NUM_CH)) ? sel_ch_c : hb_view_c;
        end
    end

endmodule

// File: tb/tb_ice_panel_ctrl.sv
// Self-checking bench for ice_panel_ctrl against a cycle-level behavioural model of the panel rules.
module tb_ice_panel_ctrl;

    localparam int unsigned NUM_PB       = 2;
    localparam int unsigned DEBOUNCE_CYC = 4;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned NUM_CH       = 2;
    localparam int unsigned LED_W        = 8;
    localparam int unsigned RST_STRETCH  = 3;
    localparam int unsigned HB_LOG2      = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  pb_n = 2'b11;
    logic [15:0] dbg_in = '0;
    logic [1:0]  pb_level;
    logic [1:0]  pb_press;
    logic        soft_reset;
    logic [1:0]  ch_sel;
    logic [7:0]  led;

    int vectors = 0;
    int miscompares = 0;

    ice_panel_ctrl #(
        .NUM_PB       (NUM_PB),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W),
        .NUM_CH       (NUM_CH),
        .LED_W        (LED_W),
        .RST_STRETCH  (RST_STRETCH),
        .HB_LOG2      (HB_LOG2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pb_n       (pb_n),
        .dbg_in     (dbg_in),
        .pb_level   (pb_level),
        .pb_press   (pb_press),
        .soft_reset (soft_reset),
        .ch_sel     (ch_sel),
        .led        (led)
    );

    always #5 clk = ~clk;

    // Behavioural model: pin history, run length of disagreeing samples, view number, lamp state.
    logic [1:0] p1, p2;
    logic [1:0] m_level, m_press;
    int         m_run [2];
    int         m_stretch;
    int         m_ch;
    logic [3:0] m_hb;
    logic [7:0] m_led;
    logic       m_soft;
    logic [14:0] obs, exp_vec;

    assign m_soft  = m_level[0] || (m_stretch != 0);
    assign obs     = {pb_level, pb_press, soft_reset, ch_sel, led};
    assign exp_vec = {m_level, m_press, m_soft, 2'(m_ch), m_led};

    task automatic model_reset();
        p1 = 2'b11; p2 = 2'b11;
        m_level = '0; m_press = '0;
        m_run[0] = 0; m_run[1] = 0;
        m_stretch = RST_STRETCH; m_ch = 0; m_hb = '0; m_led = '0;
    endtask

    task automatic model_step();
        logic [1:0] s, lvl_o, prs_o;
        logic       soft_o;
        int         ch_o;
        logic [3:0] hb_o;
        s = ~p2; p2 = p1; p1 = pb_n;
        lvl_o = m_level; prs_o = m_press; ch_o = m_ch; hb_o = m_hb;
        soft_o = lvl_o[0] || (m_stretch != 0);
        m_press = '0;
        for (int i = 0; i < 2; i++) begin
            if (s[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == DEBOUNCE_CYC) begin
                    m_level[i] = s[i];
                    m_press[i] = s[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (lvl_o[0]) m_stretch = RST_STRETCH;
        else if (m_stretch > 0) m_stretch = m_stretch - 1;
        if (soft_o) begin
            m_ch = 0; m_hb = '0; m_led = 8'hFF;
        end else begin
            m_ch = prs_o[1] ? (ch_o + 1) % (NUM_CH + 1) : ch_o;
            m_hb = hb_o + 4'd1;
            if (ch_o < NUM_CH) m_led = dbg_in[ch_o*8 +: 8];
            else               m_led = {hb_o[3], 5'b00000, lvl_o};
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) model_reset();
        else         model_step();
    end

    task automatic test_reset();
        int hi = 0;
        resetn = 1'b0; pb_n = 2'b11;
        repeat (3) begin
            @(negedge clk);
            if (soft_reset !== 1'b1 || led !== 8'h00 || ch_sel !== 2'd0 || pb_level !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_state got sr=%b led=%h ch=%0d lvl=%b want sr=1 led=00 ch=0 lvl=00",
                         soft_reset, led, ch_sel, pb_level);
            end
            vectors++;
        end
        @(posedge clk); #1 resetn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL reset_release c=%0d got %h want %h", c, obs, exp_vec);
            end
            vectors++;
            if (soft_reset) hi++;
            dbg_in = 16'($urandom);
        end
        if (hi != 3) begin
            miscompares++;
            $display("FAIL reset_stretch_len got %0d want 3", hi);
        end
        vectors++;
    endtask

    task automatic test_bounce();
        int presses = 0;
        for (int r = 0; r < 6; r++) begin
            int len = $urandom_range(1, 3);
            for (int c = 0; c < len + 8; c++) begin
                @(negedge clk);
                if (obs !== exp_vec) begin
                    miscompares++;
                    $display("FAIL bounce r=%0d c=%0d got %h want %h", r, c, obs, exp_vec);
                end
                vectors++;
                if (pb_press[1]) presses++;
                pb_n[1] = (c < len) ? 1'b0 : 1'b1;
                dbg_in = 16'($urandom);
            end
        end
        if (presses != 0 || pb_level[1] !== 1'b0 || ch_sel !== 2'd0) begin
            miscompares++;
            $display("FAIL bounce_reject got press=%0d lvl1=%b ch=%0d want 0 0 0", presses, pb_level[1], ch_sel);
        end
        vectors++;
    endtask

    task automatic test_clean_press();
        int lat = 0;
        int presses = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL clean_press c=%0d got %h want %h", c, obs, exp_vec);
            end
            vectors++;
            if (pb_level[1] && lat == 0) lat = c;
            if (pb_press[1]) presses++;
            pb_n[1] = (c < 12) ? 1'b0 : 1'b1;
            dbg_in = 16'($urandom);
        end
        if (lat != DEBOUNCE_CYC + 2 || presses != 1 || ch_sel !== 2'd1) begin
            miscompares++;
            $display("FAIL press_latency got lat=%0d press=%0d ch=%0d want 6 1 1", lat, presses, ch_sel);
        end
        vectors++;
    endtask

    task automatic test_wrap_heartbeat();
        logic [1:0] want_ch [2];
        want_ch[0] = 2'd2; want_ch[1] = 2'd0;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (obs !== exp_vec) begin
                    miscompares++;
                    $display("FAIL wrap_hb p=%0d c=%0d got %h want %h", p, c, obs, exp_vec);
                end
                vectors++;
                pb_n[1] = (c < 10) ? 1'b0 : 1'b1;
                dbg_in = 16'($urandom);
            end
            if (ch_sel !== want_ch[p]) begin
                miscompares++;
                $display("FAIL wrap_ch p=%0d got %0d want %0d", p, ch_sel, want_ch[p]);
            end
            vectors++;
        end
    endtask

    task automatic test_soft_reset_button();
        int hi = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL sr_setup c=%0d got %h want %h", c, obs, exp_vec);
            end
            vectors++;
            pb_n[1] = (c < 8) ? 1'b0 : 1'b1;
            dbg_in = 16'($urandom);
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL sr_button c=%0d got %h want %h", c, obs, exp_vec);
            end
            vectors++;
            if (soft_reset) hi++;
            pb_n[0] = (c < 10) ? 1'b0 : 1'b1;
            dbg_in = 16'($urandom);
        end
        if (hi != 13 || ch_sel !== 2'd0) begin
            miscompares++;
            $display("FAIL sr_window got hi=%0d ch=%0d want 13 0", hi, ch_sel);
        end
        vectors++;
    endtask

    task automatic test_simultaneous();
        int nonzero = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL simul c=%0d got %h want %h", c, obs, exp_vec);
            end
            vectors++;
            if (ch_sel != 2'd0) nonzero++;
            pb_n = (c < 12) ? 2'b00 : 2'b11;
            dbg_in = 16'($urandom);
        end
        if (nonzero != 0) begin
            miscompares++;
            $display("FAIL simul_priority got %0d cycles with ch!=0 want 0", nonzero);
        end
        vectors++;
        @(negedge clk); pb_n[1] = 1'b0;
        repeat (4) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        if (pb_level !== 2'b00 || soft_reset !== 1'b1 || ch_sel !== 2'd0) begin
            miscompares++;
            $display("FAIL async_reset got lvl=%b sr=%b ch=%0d want 00 1 0", pb_level, soft_reset, ch_sel);
        end
        vectors++;
        @(posedge clk); #1 resetn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL post_reset c=%0d got %h want %h", c, obs, exp_vec);
            end
            vectors++;
            pb_n[1] = (c < 10) ? 1'b0 : 1'b1;
            dbg_in = 16'($urandom);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (obs !== exp_vec) begin
                miscompares++;
                $display("FAIL random c=%0d got %h want %h", c, obs, exp_vec);
            end
            vectors++;
            if ($urandom_range(0, 11) == 0) pb_n[$urandom_range(0, 1)] ^= 1'b1;
            dbg_in = 16'($urandom);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_clean_press();
        test_wrap_heartbeat();
        test_soft_reset_button();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ice_panel_ctrl.md
Name: ice_panel_ctrl

Overview:
- Parametrised front-panel controller for the ICE board. Replaces the bare inverted-pushbutton reset and the fixed 8-bit debug-to-LED wiring.
- Synchronises and debounces N active-low pushbuttons and produces a stretched soft-reset for ice_controller.
- Multiplexes several debug channels onto the LED bank. A button cycles the selected channel, with one extra heartbeat view.
- Sits between the board pins and ice_controller in the top level.

Parameters:
- NUM_PB, 4, pushbutton count; must be >= 2. pb 0 is reset, pb 1 is channel-select.
- DEBOUNCE_CYC, 50000, consecutive stable cycles required to accept a new button level.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYC.
- NUM_CH, 4, number of debug channels.
- LED_W, 8, LED and debug channel width.
- RST_STRETCH, 16, cycles soft_reset stays high after its cause ends.
- HB_LOG2, 24, heartbeat counter width; the MSB drives the heartbeat LED.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- pb_n  input  NUM_PB  raw active-low pushbuttons, asynchronous to clk.
- dbg_in  input  NUM_CH*LED_W  debug channels; channel k occupies bits [k*LED_W +: LED_W].
- pb_level  output  NUM_PB  debounced level; 1 = pressed.
- pb_press  output  NUM_PB  one-cycle pulse on each debounced press.
- soft_reset  output  1  active-high reset to downstream logic.
- ch_sel  output  $clog2(NUM_CH+1)  current LED view.
- led  output  LED_W  LED drive; 1 = lit.

Behaviour:
- Reset (resetn low, async) sets:
  - sync flops to 1 (released);
  - pb_level = 0, pb_press = 0, all debounce counters = 0;
  - ch_sel = 0, heartbeat counter = 0, led = 0;
  - soft_reset = 1, stretch counter = RST_STRETCH.
- Synchroniser: per button, two-flop synchroniser on ~pb_n. The synchronised value s lags the pin by 2 cycles.
- Debounce, per button:
  - If s == pb_level, counter clears to 0.
  - Otherwise counter increments.
  - When the counter reaches DEBOUNCE_CYC-1 while s still differs, pb_level toggles on the next edge and the counter clears.
  - A bounce shorter than DEBOUNCE_CYC cycles changes nothing.
  - Total pin-to-pb_level latency is DEBOUNCE_CYC+2 cycles.
- pb_press[i] is high for exactly one cycle: the cycle after pb_level[i] goes 0 to 1. Release produces no pulse.
- Soft reset:
  - While pb_level[0] = 1, soft_reset = 1 and the stretch counter is reloaded to RST_STRETCH.
  - Otherwise, the counter decrements while nonzero. soft_reset = 1 iff pb_level[0] = 1 or the counter != 0.
  - After resetn deasserts, soft_reset stays high exactly RST_STRETCH cycles.
  - After pb 0 debounced release, soft_reset stays high exactly RST_STRETCH cycles.
- Channel select:
  - On pb_press[1], ch_sel advances by one, wrapping NUM_CH back to 0. The range is 0..NUM_CH.
  - While soft_reset = 1, ch_sel is forced to 0 and pb_press[1] is ignored. Soft reset has priority when both happen in the same cycle.
- Heartbeat counter: free-running HB_LOG2-bit up-counter that wraps naturally. Held at 0 while soft_reset = 1.
- LED output is registered, one cycle after the selected source:
  - ch_sel < NUM_CH: led = dbg_in channel ch_sel.
  - ch_sel == NUM_CH (heartbeat view): led[LED_W-1] = heartbeat MSB; led[LED_W-2:NUM_PB] = 0; led[NUM_PB-1:0] = pb_level. Requires NUM_PB <= LED_W-1.
  - While soft_reset = 1: led = all ones (lamp test).
- Pressing other buttons (index >= 2) affects only pb_level and pb_press.

Decomposition:
- Package ice_panel_pkg holds the button-index constants PB_RESET = 0 and PB_CHSEL = 1, plus the ch_sel width function.
- Sub-module ice_debounce (parameters DEBOUNCE_CYC, CNT_W) implements one button: synchroniser, counter, level and press pulse. It is instantiated NUM_PB times via generate.
- Soft reset, channel select, heartbeat and LED mux live in the top of the block.

Test Plan (DEBOUNCE_CYC=4, RST_STRETCH=3, NUM_CH=2, NUM_PB=2, LED_W=8, HB_LOG2=4):
- Reset release: resetn low then high, pb_n=2'b11 -> soft_reset high exactly 3 cycles after release, led=8'hFF during that window, then led = dbg_in channel 0, ch_sel=0.
- Bounce reject: pb_n[1] low for 3 cycles, then high -> pb_level[1] stays 0, no pb_press, ch_sel unchanged.
- Clean press: pb_n[1] held low -> pb_level[1] rises 6 cycles after the pin edge, one-cycle pb_press[1], ch_sel 0→1, led = dbg_in channel 1 one cycle later.
- Wrap and heartbeat: two more presses -> ch_sel 1→2, where led[7] toggles every 8 cycles and led[1:0] = pb_level; then 2→0.
- Soft reset via button: ch_sel=1, pb_n[0] held low 10 cycles -> soft_reset high from debounce until 3 cycles after debounced release, ch_sel forced to 0, led=8'hFF throughout.
- Simultaneous: pb_press[1] arrives while soft_reset=1 -> ch_sel remains 0. Assert resetn mid-debounce -> counters clear immediately and pb_level=0.
